// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU request/payload bundle and the registered common data bus it feeds.
`ifndef NUM_CDBBITS
`define NUM_CDBBITS 39
`endif
`ifndef CDB_ON_FIELD
`define CDB_ON_FIELD 38
`endif

interface cdb_arbiter_if #(
   parameter int NUM_FU    = 5,
   parameter int PAYLOAD_W = `NUM_CDBBITS - 1
);
   logic                        flush;
   logic [NUM_FU-1:0]           req;
   logic [NUM_FU*PAYLOAD_W-1:0] payload;
   logic [`NUM_CDBBITS-1:0]     cdb;
   logic [NUM_FU-1:0]           grant;
   logic [31:0]                 bcast_cnt;
   logic [31:0]                 conflict_cnt;
   modport master (output flush, req, payload, input cdb, grant, bcast_cnt, conflict_cnt);
   modport slave  (input flush, req, payload, output cdb, grant, bcast_cnt, conflict_cnt);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin pick of one FU result per cycle onto the registered CDB.
// Optional broadcast/conflict counters are enabled by defining CDB_PERF_CNT_EN.
`ifndef NUM_CDBBITS
`define NUM_CDBBITS 39
`endif
`ifndef CDB_ON_FIELD
`define CDB_ON_FIELD 38
`endif

module cdb_arbiter #(
   parameter int NUM_FU    = 5,
   parameter int PAYLOAD_W = `NUM_CDBBITS - 1,
   parameter int PTR_W     = $clog2(NUM_FU)
) (
   input logic             clk,
   input logic             rst,
   cdb_arbiter_if.slave    bus
);
   logic [PTR_W-1:0]     ptr_q, ptr_d, w;
   logic                 hit;
   logic                 on_q, on_d;
   logic [PAYLOAD_W-1:0] pl_q, pl_d;
   logic [NUM_FU-1:0]    grant_q, grant_d;

   always_comb begin
      w   = '0;
      hit = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (!hit && bus.req[(int'(ptr_q) + i) % NUM_FU]) begin
            hit = 1'b1;
            w   = PTR_W'((int'(ptr_q) + i) % NUM_FU);
         end
      end
      on_d    = hit && !bus.flush;
      pl_d    = on_d ? bus.payload[w*PAYLOAD_W +: PAYLOAD_W] : pl_q;
      grant_d = on_d ? NUM_FU'(1) << w : '0;
      ptr_d   = !on_d ? ptr_q : (w == PTR_W'(NUM_FU - 1)) ? '0 : w + PTR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         on_q    <= 1'b0;
         pl_q    <= '0;
         grant_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         on_q    <= on_d;
         pl_q    <= pl_d;
         grant_q <= grant_d;
      end
   end

   assign bus.cdb   = {on_q, pl_q};
   assign bus.grant = grant_q;

`ifdef CDB_PERF_CNT_EN
   logic [31:0] bcast_q, bcast_d, conflict_q, conflict_d;

   always_comb begin
      bcast_d    = bcast_q + 32'(on_d);
      conflict_d = conflict_q + 32'(($countones(bus.req) >= 2) && !bus.flush);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcast_q    <= '0;
         conflict_q <= '0;
      end else begin
         bcast_q    <= bcast_d;
         conflict_q <= conflict_d;
      end
   end

   assign bus.bcast_cnt    = bcast_q;
   assign bus.conflict_cnt = conflict_q;
`else
   assign bus.bcast_cnt    = '0;
   assign bus.conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of rotation, flush, reset, handshake and counters.
`ifndef NUM_CDBBITS
`define NUM_CDBBITS 39
`endif

module tb_cdb_arbiter;
   localparam int N  = 5;
   localparam int PW = `NUM_CDBBITS - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tc  = 0;
   int   fc  = 0;
   logic [PW-1:0] pl [N];

   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_FU(N), .PAYLOAD_W(PW)) bus ();
   cdb_arbiter #(.NUM_FU(N), .PAYLOAD_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tc++;
      assert (obs === exp) else begin
         fc++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pl();
      bus.payload = {pl[4], pl[3], pl[2], pl[1], pl[0]};
   endtask

   task automatic on_fu(input string tag, input int i);
      chk({tag, "_grant"}, 64'(bus.grant), 64'(5'b1 << i));
      chk({tag, "_cdb"}, 64'(bus.cdb), 64'({1'b1, pl[i]}));
   endtask

   initial begin
      for (int i = 0; i < N; i++) pl[i] = {3'(i), 3'(1 << (i % 3)), 32'hA500_0000 | 32'(i)};
      drive_pl();
      bus.req   = '0;
      bus.flush = 1'b0;
      step();
      chk("rst_cdb", 64'(bus.cdb), 64'h0);
      chk("rst_grant", 64'(bus.grant), 64'h0);
      chk("rst_bcast", 64'(bus.bcast_cnt), 64'h0);
      chk("rst_conflict", 64'(bus.conflict_cnt), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      // all five request: strict rotation from index 0
      bus.req = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         step();
         on_fu($sformatf("rr%0d", k), k % N);
      end
`ifdef CDB_PERF_CNT_EN
      chk("rr_bcast", 64'(bus.bcast_cnt), 64'd6);
      chk("rr_conflict", 64'(bus.conflict_cnt), 64'd6);
`else
      chk("rr_bcast_off", 64'(bus.bcast_cnt), 64'd0);
      chk("rr_conflict_off", 64'(bus.conflict_cnt), 64'd0);
`endif
      // async reset while FU2 is broadcasting
      bus.req = 5'b00100;
      step();
      on_fu("pre_rst", 2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cdb", 64'(bus.cdb), 64'h0);
      chk("mid_rst_grant", 64'(bus.grant), 64'h0);
      chk("mid_rst_bcast", 64'(bus.bcast_cnt), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      step();
      on_fu("post_rst", 2);
      // ptr=3: flush wins, then search 3,4,0,1 lands on FU1
      bus.req   = 5'b00110;
      bus.flush = 1'b1;
      step();
      chk("flush_cdb", 64'(bus.cdb), 64'({1'b0, pl[2]}));
      chk("flush_grant", 64'(bus.grant), 64'h0);
      bus.flush = 1'b0;
      step();
      on_fu("post_flush", 1);
      // ptr=2: load result broadcast exactly once
      pl[4] = {3'd4, 3'b010, 32'h1234_5678};
      drive_pl();
      bus.req = 5'b10000;
      step();
      on_fu("ls_on", 4);
      bus.req = 5'b00000;
      step();
      chk("ls_off_cdb", 64'(bus.cdb), 64'({1'b0, pl[4]}));
      chk("ls_off_grant", 64'(bus.grant), 64'h0);
      step();
      chk("ls_hold_data", 64'(bus.cdb[31:0]), 64'h1234_5678);
      chk("ls_hold_on", 64'(bus.cdb[`NUM_CDBBITS-1]), 64'h0);
      // ptr=0: grant FU3 to leave ptr=4, then wrap to FU0 and FU1
      bus.req = 5'b01000;
      step();
      on_fu("wrap_fu3", 3);
      bus.req = 5'b00011;
      step();
      on_fu("wrap_fu0", 0);
      step();
      on_fu("wrap_fu1", 1);
      bus.req = 5'b00000;
      step();
      chk("idle_grant", 64'(bus.grant), 64'h0);
      // lone requester is served back to back
      bus.req = 5'b00100;
      step();
      on_fu("single_a", 2);
      step();
      on_fu("single_b", 2);
`ifdef CDB_PERF_CNT_EN
      force dut.bcast_q = 32'hFFFF_FFFF;
      #1 release dut.bcast_q;
      chk("bcast_preload", 64'(bus.bcast_cnt), 64'hFFFF_FFFF);
      step();
      chk("bcast_wrap", 64'(bus.bcast_cnt), 64'h0);
`else
      step();
      chk("end_bcast_off", 64'(bus.bcast_cnt), 64'd0);
      chk("end_conflict_off", 64'(bus.conflict_cnt), 64'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", tc, fc);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end
endmodule
